sdspi_bench_ctrl: RTL and testbench
===================================

Name: sdspi_bench_ctrl

Overview:
- Measurement sequencer that sits directly upstream of the SD-SPI read test harness (the sdspi_system block).
- Drives the harness's start / n_blocks / cmd18 / sclk_speed inputs and its reset, and times each run by counting clk cycles until the harness raises finish.
- Sweeps a range of SCLK speed codes and both read modes (single-block CMD17 loop, multi-block CMD18).
- Emits one timing record per run on a valid/ready stream to the downstream reporting stage.

Parameters:
- RST_CYCLES, 4: cycles dut_rst is held high before each run (min 1).
- TIMEOUT, 32'h0FFF_FFFF: run cycle limit; a run reaching it is aborted and flagged.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- go, input, 1: start-sweep pulse; ignored while busy=1.
- cfg_n_blocks, input, 32: blocks per run; latched on accepted go.
- cfg_speed_min, input, 5: first sclk_speed code; latched on go.
- cfg_speed_max, input, 5: last sclk_speed code, inclusive; latched on go.
- cfg_mode_mask, input, 2: bit0 enables cmd18=0 runs, bit1 enables cmd18=1 runs; latched on go.
- busy, output, 1: high from accepted go until the done pulse, inclusive.
- done, output, 1: one-cycle pulse at end of sweep.
- err, output, 1: valid with done; set for an invalid configuration.
- dut_rst, output, 1: reset to the harness.
- dut_start, output, 1: start to the harness.
- dut_n_blocks, output, 32: n_blocks to the harness.
- dut_cmd18, output, 1: cmd18 to the harness.
- dut_sclk_speed, output, 5: sclk_speed to the harness.
- dut_finish, input, 1: finish from the harness; level, stays high until the harness is reset.
- res_valid, output, 1: result record valid.
- res_ready, input, 1: downstream accept.
- res_data, output, 40: result record.
  - [39:35] speed code.
  - [34] cmd18.
  - [33] timeout.
  - [32] last record of the sweep.
  - [31:0] cycle count.

Behaviour:
- Reset values: busy=0, done=0, err=0, dut_rst=1, dut_start=0, res_valid=0, res_data=0, dut_n_blocks=0, dut_cmd18=0, dut_sclk_speed=0; FSM goes to IDLE.
- rst asserted mid-run aborts immediately. Any pending record is dropped and no done is issued.
- dut_rst=0 only in ARM and RUN; it is 1 in every other state.
- FSM states:
  - IDLE: on go, latch cfg_*.
    - Invalid config (speed_min > speed_max, or mode_mask == 0, or n_blocks == 0): go to FINISH with err=1; no run.
    - Otherwise: speed <= speed_min; mode <= lowest enabled mode (0 before 1); go to DUT_RST.
  - DUT_RST: hold dut_rst=1 for exactly RST_CYCLES cycles, then go to ARM.
    - dut_* config outputs present the current speed, mode and n_blocks from this state until the run ends.
  - ARM: exactly 1 cycle; dut_start=1; cycle counter cleared to 0; go to RUN.
  - RUN: dut_start=0.
    - Each cycle with dut_finish=0, counter increments by 1.
    - dut_finish=1: go to RECORD with timeout=0; the counter does not increment that cycle.
    - Counter == TIMEOUT with dut_finish=0: go to RECORD with timeout=1 and count=TIMEOUT. The counter never exceeds TIMEOUT.
    - If finish and the limit occur in the same cycle, finish wins (timeout=0).
  - RECORD: res_valid=1 and res_data stable until the cycle res_valid & res_ready; then go to NEXT.
    - last=1 iff this is the final (speed, mode) pair of the sweep.
  - NEXT: 1 cycle; advance the iteration.
    - If the other mode is enabled and mode==0: mode <= 1.
    - Otherwise: mode <= lowest enabled mode and speed <= speed+1.
    - If the record just sent had last=1: go to FINISH; else go to DUT_RST.
    - Speed compare uses 6 bits, so speed_max=31 terminates without wrap.
- FINISH: done=1 for one cycle; err as determined in IDLE (0 for a normal sweep); busy=1 this cycle; next state IDLE.
- Run count per sweep = (speed_max − speed_min + 1) × popcount(mode_mask).
- Cycle count semantics: number of RUN cycles observed with dut_finish low. ARM and the finish cycle are excluded.

Test Plan:
- Single run: go, n_blocks=1, speed 3..3, mask=2'b10, harness model raises finish 100 cycles after start -> exactly 1 record.
  - res_data = {5'd3, 1, 0, 1, 32'd100}.
  - Afterwards done=1 for 1 cycle with err=0, then busy=0.
- Sweep order: speed 2..4, mask=2'b11 -> 6 records in order (2,0),(2,1),(3,0),(3,1),(4,0),(4,1).
  - last=1 only on (4,1).
  - dut_rst high for 4 cycles before each dut_start pulse.
- Timeout: TIMEOUT=50, harness never finishes -> record count=50, timeout=1; sweep continues to the next pair.
- Backpressure: res_ready held 0 for 20 cycles -> res_valid and res_data stable throughout; no new dut_start until the handshake completes.
- Config error: speed_min=5, speed_max=4 -> no dut_start and no record; done=1 with err=1 one cycle after go.
- Mid-run reset and edge cases:
  - rst during RUN -> next cycle all outputs at reset values and dut_rst=1; a subsequent go runs cleanly.
  - go while busy is ignored.
  - speed 31..31 terminates after its runs.

Source files
------------

// File: rtl/sdspi_bench_ctrl.sv
// rtl/sdspi_bench_ctrl.sv - sweep sequencer that times SD-SPI harness read runs
// and streams one timing record per (speed, mode) pair.
module sdspi_bench_ctrl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter logic [31:0] TIMEOUT    = 32'h0FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_go,
  input  logic [31:0] i_cfg_n_blocks,
  input  logic [4:0]  i_cfg_speed_min,
  input  logic [4:0]  i_cfg_speed_max,
  input  logic [1:0]  i_cfg_mode_mask,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_dut_rst,
  output logic        o_dut_start,
  output logic [31:0] o_dut_n_blocks,
  output logic        o_dut_cmd18,
  output logic [4:0]  o_dut_sclk_speed,
  input  logic        i_dut_finish,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [39:0] o_res_data
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DUT_RST, S_ARM, S_RUN, S_RECORD, S_NEXT, S_FINISH
  } state_t;

  state_t        r_state, w_next;
  logic [RW-1:0] r_rst_cnt;
  logic [31:0]   r_cnt;
  logic [31:0]   r_n_blocks;
  logic [4:0]    r_speed;
  logic [4:0]    r_speed_max;
  logic [1:0]    r_mask;
  logic          r_mode;
  logic          r_timeout;
  logic          r_err;
  logic          w_cfg_bad;
  logic          w_last;
  logic          w_rst_done;
  logic          w_limit;

  assign w_cfg_bad  = (i_cfg_speed_min > i_cfg_speed_max) ||
                      (i_cfg_mode_mask == 2'b00) || (i_cfg_n_blocks == 32'd0);
  // 6-bit compare so a sweep ending at speed 31 cannot wrap back to 0
  assign w_last     = (({1'b0, r_speed} + 6'd1) > {1'b0, r_speed_max}) &&
                      (r_mode || !r_mask[1]);
  assign w_rst_done = (r_rst_cnt == RW'(RST_CYCLES - 1));
  assign w_limit    = (r_cnt == TIMEOUT);

  assign o_dut_n_blocks   = r_n_blocks;
  assign o_dut_cmd18      = r_mode;
  assign o_dut_sclk_speed = r_speed;

  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_dut_rst   = 1'b1;
    o_dut_start = 1'b0;
    o_res_valid = 1'b0;
    o_res_data  = 40'd0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_go) w_next = w_cfg_bad ? S_FINISH : S_DUT_RST;
      end
      S_DUT_RST: if (w_rst_done) w_next = S_ARM;
      S_ARM: begin
        o_dut_rst   = 1'b0;
        o_dut_start = 1'b1;
        w_next      = S_RUN;
      end
      S_RUN: begin
        o_dut_rst = 1'b0;
        if (i_dut_finish || w_limit) w_next = S_RECORD;
      end
      S_RECORD: begin
        o_res_valid = 1'b1;
        o_res_data  = {r_speed, r_mode, r_timeout, w_last, r_cnt};
        if (i_res_ready) w_next = S_NEXT;
      end
      S_NEXT:   w_next = w_last ? S_FINISH : S_DUT_RST;
      S_FINISH: begin
        o_done = 1'b1;
        o_err  = r_err;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rst_cnt   <= '0;
      r_cnt       <= 32'd0;
      r_n_blocks  <= 32'd0;
      r_speed     <= 5'd0;
      r_speed_max <= 5'd0;
      r_mask      <= 2'b00;
      r_mode      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (i_go) begin
          r_n_blocks  <= i_cfg_n_blocks;
          r_speed     <= i_cfg_speed_min;
          r_speed_max <= i_cfg_speed_max;
          r_mask      <= i_cfg_mode_mask;
          r_mode      <= !i_cfg_mode_mask[0];
          r_err       <= w_cfg_bad;
          r_rst_cnt   <= '0;
        end
        S_DUT_RST: r_rst_cnt <= r_rst_cnt + RW'(1);
        S_ARM:     r_cnt <= 32'd0;
        S_RUN: begin
          // finish takes priority over the limit; the count freezes at TIMEOUT
          if (i_dut_finish)  r_timeout <= 1'b0;
          else if (w_limit)  r_timeout <= 1'b1;
          else               r_cnt <= r_cnt + 32'd1;
        end
        S_NEXT: begin
          r_rst_cnt <= '0;
          if (!r_mode && r_mask[1]) begin
            r_mode <= 1'b1;
          end else begin
            r_mode  <= !r_mask[0];
            r_speed <= r_speed + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdspi_bench_ctrl.sv
// tb/tb_sdspi_bench_ctrl.sv - directed bench for sdspi_bench_ctrl: sweep vectors,
// backpressure, busy-go, mid-run reset, and timeout on a second instance.
module tb_sdspi_bench_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: finishing harness model
  logic        go_a = 1'b0, ready_a = 1'b1;
  logic [31:0] nblk_a = 32'd0;
  logic [4:0]  smin_a = 5'd0, smax_a = 5'd0;
  logic [1:0]  mask_a = 2'b00;
  logic        busy_a, done_a, err_a, drst_a, dstart_a, cmd18_a, valid_a;
  logic [31:0] dnblk_a;
  logic [4:0]  dspeed_a;
  logic [39:0] data_a;
  logic        fin_a = 1'b0, act_a = 1'b0;
  int          k_a = 0;
  int          hlat = 1;

  // instance B: harness that never finishes
  logic        go_b = 1'b0, ready_b = 1'b1;
  logic [31:0] nblk_b = 32'd0;
  logic [4:0]  smin_b = 5'd0, smax_b = 5'd0;
  logic [1:0]  mask_b = 2'b00;
  logic        busy_b, done_b, err_b, drst_b, dstart_b, cmd18_b, valid_b;
  logic [31:0] dnblk_b;
  logic [4:0]  dspeed_b;
  logic [39:0] data_b;

  int n_chk = 0;
  int n_err = 0;

  sdspi_bench_ctrl #(.RST_CYCLES(4), .TIMEOUT(32'h0FFF_FFFF)) u_dut_a (
    .clk(clk), .rst(rst), .i_go(go_a), .i_cfg_n_blocks(nblk_a),
    .i_cfg_speed_min(smin_a), .i_cfg_speed_max(smax_a), .i_cfg_mode_mask(mask_a),
    .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_dut_rst(drst_a),
    .o_dut_start(dstart_a), .o_dut_n_blocks(dnblk_a), .o_dut_cmd18(cmd18_a),
    .o_dut_sclk_speed(dspeed_a), .i_dut_finish(fin_a), .o_res_valid(valid_a),
    .i_res_ready(ready_a), .o_res_data(data_a)
  );

  sdspi_bench_ctrl #(.RST_CYCLES(4), .TIMEOUT(32'd50)) u_dut_b (
    .clk(clk), .rst(rst), .i_go(go_b), .i_cfg_n_blocks(nblk_b),
    .i_cfg_speed_min(smin_b), .i_cfg_speed_max(smax_b), .i_cfg_mode_mask(mask_b),
    .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_dut_rst(drst_b),
    .o_dut_start(dstart_b), .o_dut_n_blocks(dnblk_b), .o_dut_cmd18(cmd18_b),
    .o_dut_sclk_speed(dspeed_b), .i_dut_finish(1'b0), .o_res_valid(valid_b),
    .i_res_ready(ready_b), .o_res_data(data_b)
  );

  // finish rises so that exactly hlat RUN cycles see it low
  always @(posedge clk) begin
    if (drst_a) begin
      fin_a <= 1'b0; act_a <= 1'b0; k_a <= 0;
    end else if (dstart_a) begin
      act_a <= 1'b1; k_a <= 0;
    end else if (act_a && !fin_a) begin
      k_a <= k_a + 1;
      if (k_a + 1 == hlat) fin_a <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"},   64'(busy_a),   64'd0);
    check({tag, "_done"},   64'(done_a),   64'd0);
    check({tag, "_err"},    64'(err_a),    64'd0);
    check({tag, "_dutrst"}, 64'(drst_a),   64'd1);
    check({tag, "_start"},  64'(dstart_a), 64'd0);
    check({tag, "_valid"},  64'(valid_a),  64'd0);
    check({tag, "_data"},   64'(data_a),   64'd0);
    check({tag, "_nblk"},   64'(dnblk_a),  64'd0);
    check({tag, "_cmd18"},  64'(cmd18_a),  64'd0);
    check({tag, "_speed"},  64'(dspeed_a), 64'd0);
  endtask

  task automatic run_sweep(input logic [4:0] smin, input logic [4:0] smax,
                           input logic [1:0] mask, input logic [31:0] nblk,
                           input int lat, input logic exp_err);
    logic [39:0] expq[$];
    logic [31:0] latv;
    logic [4:0]  sv;
    int nrec = 0, rstrun = 0, nstart = 0;
    bit done_seen = 1'b0;
    latv = lat;
    if (!exp_err)
      for (int s = smin; s <= smax; s++)
        for (int m = 0; m < 2; m++)
          if (mask[m]) begin
            sv = 5'(s);
            expq.push_back({sv, (m == 1), 1'b0, 1'b0, latv});
          end
    if (expq.size() > 0) expq[expq.size()-1][32] = 1'b1;
    hlat = lat; smin_a = smin; smax_a = smax; mask_a = mask; nblk_a = nblk;
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      if (dstart_a) begin
        check("rst_len", 64'(rstrun), (nstart == 0) ? 64'd4 : 64'd6);
        if (nstart < expq.size()) begin
          check("dut_speed", 64'(dspeed_a), 64'(expq[nstart][39:35]));
          check("dut_cmd18", 64'(cmd18_a), 64'(expq[nstart][34]));
          check("dut_nblk",  64'(dnblk_a), 64'(nblk));
        end else check("extra_start", 64'(nstart), 64'(expq.size()));
        nstart++;
      end
      rstrun = drst_a ? rstrun + 1 : 0;
      if (valid_a) begin
        if (nrec < expq.size()) check("res_data", 64'(data_a), 64'(expq[nrec]));
        else check("extra_rec", 64'(nrec), 64'(expq.size()));
        nrec++;
      end
      if (done_a) begin
        check("done_err", 64'(err_a), 64'(exp_err));
        check("rec_count", 64'(nrec), 64'(expq.size()));
        check("busy_at_done", 64'(busy_a), 64'd1);
        if (exp_err) check("err_latency", 64'(c), 64'd0);
        done_seen = 1'b1;
      end
      @(negedge clk);
    end
    if (!done_seen) check("sweep_done_timeout", 64'd0, 64'd1);
    check("done_pulse_end", 64'(done_a), 64'd0);
    check("busy_after", 64'(busy_a), 64'd0);
  endtask

  typedef struct {
    logic [4:0]  smin;
    logic [4:0]  smax;
    logic [1:0]  mask;
    logic [31:0] nblk;
    int          lat;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [39:0] held, exp_rec;
    logic [39:0] exp_b[2];
    int cnt, nstart, nrec, bad;
    bit seen;

    vecs[0] = '{5'd3,  5'd3,  2'b10, 32'd1, 100, 1'b0};
    vecs[1] = '{5'd2,  5'd4,  2'b11, 32'd8, 10,  1'b0};
    vecs[2] = '{5'd5,  5'd4,  2'b01, 32'd1, 10,  1'b1};
    vecs[3] = '{5'd0,  5'd0,  2'b00, 32'd1, 10,  1'b1};
    vecs[4] = '{5'd1,  5'd1,  2'b01, 32'd0, 10,  1'b1};
    vecs[5] = '{5'd31, 5'd31, 2'b11, 32'd2, 5,   1'b0};
    vecs[6] = '{5'd7,  5'd9,  2'b01, 32'd3, 7,   1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      run_sweep(vecs[v].smin, vecs[v].smax, vecs[v].mask, vecs[v].nblk, vecs[v].lat, vecs[v].err);

    // backpressure, with an ignored go while busy
    hlat = 12; smin_a = 5'd6; smax_a = 5'd7; mask_a = 2'b01; nblk_a = 32'd4;
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (valid_a) seen = 1'b1; else @(negedge clk);
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    ready_a = 1'b0;
    held = data_a;
    exp_rec = {5'd6, 1'b0, 1'b0, 1'b0, 32'd12};
    check("bp_first_rec", 64'(held), 64'(exp_rec));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      go_a = (i == 5);
      smin_a = 5'd20; smax_a = 5'd21; mask_a = 2'b11;
      @(negedge clk);
      if (!valid_a || data_a !== held || dstart_a) bad++;
    end
    go_a = 1'b0;
    check("bp_stall_stable", 64'(bad), 64'd0);
    ready_a = 1'b1;
    @(negedge clk);
    nstart = 0; nrec = 0; seen = 1'b0;
    exp_rec = {5'd7, 1'b0, 1'b0, 1'b1, 32'd12};
    for (int c = 0; c < 300 && !seen; c++) begin
      if (dstart_a) begin
        check("bp_next_speed", 64'(dspeed_a), 64'd7);
        nstart++;
      end
      if (valid_a) begin
        check("bp_second_rec", 64'(data_a), 64'(exp_rec));
        nrec++;
      end
      if (done_a) seen = 1'b1;
      @(negedge clk);
    end
    check("bp_done", 64'(seen), 64'd1);
    check("bp_starts", 64'(nstart), 64'd1);
    check("bp_recs", 64'(nrec), 64'd1);

    // mid-run reset
    hlat = 40; smin_a = 5'd1; smax_a = 5'd2; mask_a = 2'b11; nblk_a = 32'd5;
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (dstart_a) seen = 1'b1;
      @(negedge clk);
    end
    check("mr_started", 64'(seen), 64'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_a("midrst");
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_a || valid_a || dstart_a) cnt++;
    end
    check("mr_quiet", 64'(cnt), 64'd0);
    run_sweep(vecs[0].smin, vecs[0].smax, vecs[0].mask, vecs[0].nblk, vecs[0].lat, vecs[0].err);

    // timeout on instance B
    exp_b[0] = {5'd4, 1'b0, 1'b1, 1'b0, 32'd50};
    exp_b[1] = {5'd5, 1'b0, 1'b1, 1'b1, 32'd50};
    smin_b = 5'd4; smax_b = 5'd5; mask_b = 2'b01; nblk_b = 32'd1;
    go_b = 1'b1;
    @(negedge clk);
    go_b = 1'b0;
    nrec = 0; seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      if (valid_b) begin
        if (nrec < 2) check("to_rec", 64'(data_b), 64'(exp_b[nrec]));
        nrec++;
      end
      if (done_b) begin
        check("to_err", 64'(err_b), 64'd0);
        seen = 1'b1;
      end
      @(negedge clk);
    end
    check("to_done", 64'(seen), 64'd1);
    check("to_recs", 64'(nrec), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
